// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling stage.
//   POOL_MAX / POOL_AVG : reduction mode selectors
//   ST_IDLE / ST_ACTIVE : frame-tracking FSM encoding
//   clog2               : counter width helper (never returns less than 1)
package pool_pkg;

  localparam int POOL_MAX = 0;
  localparam int POOL_AVG = 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Ceiling log2, clamped to 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pool_reduce2.sv
// Registered two-input reducer with a valid-gated load.
//   MODE=POOL_MAX : y <= max(a, b) (unsigned)
//   MODE=POOL_AVG : y <= a + b + BIAS, computed at OUT_W bits
// Ports:
//   clk, rst  : clock, async active-low reset
//   load      : load enable (stage valid); register holds otherwise
//   a, b      : IN_W-bit operands
//   y         : OUT_W-bit registered result
module pool_reduce2
  import pool_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int MODE  = POOL_MAX,
  parameter int BIAS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [OUT_W-1:0] y
);

  logic [OUT_W-1:0] y_d, y_q;

  always_comb begin
    y_d = y_q;
    if (load) begin
      if (MODE == POOL_AVG) y_d = OUT_W'(a) + OUT_W'(b) + OUT_W'(BIAS);
      else                  y_d = (a >= b) ? OUT_W'(a) : OUT_W'(b);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y_q <= '0;
    else      y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/max_pool_2x2_stage.sv
// 2x2 window pooling stage with output framing.
// Reduces each incoming 2x2 window to one pixel (max or rounded average)
// through a 2-deep pipeline, and tags the output stream with row-end and
// frame-end pulses for an OUT_W x OUT_H pooled image.
// Ports:
//   clk, rst            : clock, async active-low reset
//   Data_In1..Data_In4  : window pixels TL, TR, BL, BR
//   Valid_In            : one window per asserted cycle, no backpressure
//   Data_Out, Valid_Out : pooled pixel and its strobe (2-cycle latency)
//   Row_Last            : last pooled pixel of an output row
//   Frame_Done          : last pooled pixel of the frame
//   Busy                : frame in progress
//
// state     | meaning
// ST_IDLE   | no frame in progress, waiting for the first window
// ST_ACTIVE | frame in progress, leaves after the Frame_Done cycle
module max_pool_2x2_stage
  import pool_pkg::*;
#(
  parameter int DATA_WIDHT = 8,
  parameter int IMG_WIDHT  = 299,
  parameter int IMG_HEIGHT = 299,
  parameter int POOL_MODE  = POOL_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In1,
  input  logic [DATA_WIDHT-1:0] Data_In2,
  input  logic [DATA_WIDHT-1:0] Data_In3,
  input  logic [DATA_WIDHT-1:0] Data_In4,
  input  logic                  Valid_In,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Row_Last,
  output logic                  Frame_Done,
  output logic                  Busy
);

  localparam int OUT_W = IMG_WIDHT / 2;
  localparam int OUT_H = IMG_HEIGHT / 2;
  localparam int COL_W = clog2(OUT_W);
  localparam int ROW_W = clog2(OUT_H);

  // Average mode carries the sums at full width; the +2 rounding bias is
  // folded into the stage-2 adder so the >>2 becomes a plain bit slice.
  localparam bit IS_AVG = (POOL_MODE == POOL_AVG);
  localparam int S1_W   = IS_AVG ? DATA_WIDHT + 1 : DATA_WIDHT;
  localparam int S2_W   = IS_AVG ? DATA_WIDHT + 2 : DATA_WIDHT;
  localparam int BIAS2  = IS_AVG ? 2 : 0;

  logic [S1_W-1:0]  r12, r34;
  logic [S2_W-1:0]  r_out;

  logic             vld1_d, vld1_q;
  logic             vld2_d, vld2_q;
  logic [COL_W-1:0] col_d, col_q;
  logic [ROW_W-1:0] row_d, row_q;
  logic             row_last_d, row_last_q;
  logic             frame_done_d, frame_done_q;
  logic [0:0]       state_d, state_q;

  pool_reduce2 #(.IN_W(DATA_WIDHT), .OUT_W(S1_W), .MODE(POOL_MODE), .BIAS(0)) u_s1_top (
    .clk(clk), .rst(rst), .load(Valid_In), .a(Data_In1), .b(Data_In2), .y(r12)
  );

  pool_reduce2 #(.IN_W(DATA_WIDHT), .OUT_W(S1_W), .MODE(POOL_MODE), .BIAS(0)) u_s1_bot (
    .clk(clk), .rst(rst), .load(Valid_In), .a(Data_In3), .b(Data_In4), .y(r34)
  );

  pool_reduce2 #(.IN_W(S1_W), .OUT_W(S2_W), .MODE(POOL_MODE), .BIAS(BIAS2)) u_s2 (
    .clk(clk), .rst(rst), .load(vld1_q), .a(r12), .b(r34), .y(r_out)
  );

  // Flags are computed from the position of the pixel entering stage 2 so
  // they register in the same cycle as Valid_Out.
  always_comb begin
    vld1_d       = Valid_In;
    vld2_d       = vld1_q;
    col_d        = col_q;
    row_d        = row_q;
    row_last_d   = 1'b0;
    frame_done_d = 1'b0;
    if (vld1_q) begin
      if (col_q == COL_W'(OUT_W - 1)) begin
        row_last_d = 1'b1;
        col_d      = '0;
        if (row_q == ROW_W'(OUT_H - 1)) begin
          frame_done_d = 1'b1;
          row_d        = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // A window arriving in the Frame_Done cycle starts the next frame; the
  // IDLE->ACTIVE hop collapses into staying ACTIVE so no window is missed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Valid_In) state_d = ST_ACTIVE;
      ST_ACTIVE: if (frame_done_q && !Valid_In) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld1_q       <= 1'b0;
      vld2_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      row_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      vld1_q       <= vld1_d;
      vld2_q       <= vld2_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_last_q   <= row_last_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
    end
  end

  // In average mode the top DATA_WIDHT bits of the biased sum are (sum+2)>>2.
  assign Data_Out   = r_out[S2_W-1 -: DATA_WIDHT];
  assign Valid_Out  = vld2_q;
  assign Row_Last   = row_last_q;
  assign Frame_Done = frame_done_q;
  assign Busy       = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_max_pool_2x2_stage.sv
// Self-checking bench: a max-mode and an average-mode instance (8x6 image,
// 4x3 pooled) share the stimulus; a scoreboard queue holds expected outputs.
module tb_max_pool_2x2_stage;

  localparam int DW     = 8;
  localparam int ROWLEN = 4;
  localparam int FRAME  = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic          vin = 1'b0;

  logic [DW-1:0] dout_max, dout_avg;
  logic          vout_max, vout_avg, rl_max, rl_avg, fd_max, fd_avg, busy_max, busy_avg;

  max_pool_2x2_stage #(.DATA_WIDHT(DW), .IMG_WIDHT(8), .IMG_HEIGHT(6), .POOL_MODE(0)) u_max (
    .clk(clk), .rst(rst), .Data_In1(in1), .Data_In2(in2), .Data_In3(in3), .Data_In4(in4),
    .Valid_In(vin), .Data_Out(dout_max), .Valid_Out(vout_max), .Row_Last(rl_max),
    .Frame_Done(fd_max), .Busy(busy_max)
  );

  max_pool_2x2_stage #(.DATA_WIDHT(DW), .IMG_WIDHT(8), .IMG_HEIGHT(6), .POOL_MODE(1)) u_avg (
    .clk(clk), .rst(rst), .Data_In1(in1), .Data_In2(in2), .Data_In3(in3), .Data_In4(in4),
    .Valid_In(vin), .Data_Out(dout_avg), .Valid_Out(vout_avg), .Row_Last(rl_avg),
    .Frame_Done(fd_avg), .Busy(busy_avg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] dmax;
    logic [DW-1:0] davg;
    logic          rl;
    logic          fd;
    int            issue;
  } exp_t;

  exp_t          q[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            pos      = 0;
  int            n_out    = 0;
  logic [DW-1:0] last_max = '0;
  logic [DW-1:0] last_avg = '0;
  logic [DW-1:0] win[12][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic check_out();
    bit   ev;
    exp_t e;
    while (q.size() != 0 && q[0].issue + 2 < cyc) void'(q.pop_front());
    ev = (q.size() != 0) && (q[0].issue + 2 == cyc);
    chk("valid_out_max", vout_max, ev);
    chk("valid_out_avg", vout_avg, ev);
    if (ev) begin
      e = q.pop_front();
      chk("data_max", dout_max, e.dmax);
      chk("data_avg", dout_avg, e.davg);
      chk("row_last_max", rl_max, e.rl);
      chk("row_last_avg", rl_avg, e.rl);
      chk("frame_done_max", fd_max, e.fd);
      chk("frame_done_avg", fd_avg, e.fd);
      chk("busy_at_output_max", busy_max, 1);
      chk("busy_at_output_avg", busy_avg, 1);
      last_max = e.dmax;
      last_avg = e.davg;
      n_out++;
    end else begin
      chk("row_last_idle", {rl_max, rl_avg}, 0);
      chk("frame_done_idle", {fd_max, fd_avg}, 0);
      chk("data_hold_max", dout_max, last_max);
      chk("data_hold_avg", dout_avg, last_avg);
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic drive(input logic v, input logic [DW-1:0] a, b, c, d);
    exp_t e;
    int   sum;
    vin = v; in1 = a; in2 = b; in3 = c; in4 = d;
    if (v) begin
      sum    = int'(a) + int'(b) + int'(c) + int'(d) + 2;
      e.dmax = max4(a, b, c, d);
      e.davg = DW'(sum >> 2);
      e.rl   = (pos % ROWLEN) == ROWLEN - 1;
      e.fd   = (pos % FRAME) == FRAME - 1;
      e.issue = cyc;
      q.push_back(e);
      pos++;
    end
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0);
  endtask

  // Reset is applied mid-cycle so its effect is visibly asynchronous.
  task automatic do_reset();
    vin = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_data", {dout_max, dout_avg}, 0);
    chk("rst_valid", {vout_max, vout_avg}, 0);
    chk("rst_row_last", {rl_max, rl_avg}, 0);
    chk("rst_frame_done", {fd_max, fd_avg}, 0);
    chk("rst_busy", {busy_max, busy_avg}, 0);
    q.delete();
    pos = 0;
    n_out = 0;
    last_max = '0;
    last_avg = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 4; j++) win[i][j] = DW'($urandom_range(0, 255));
    for (int j = 0; j < 4; j++) win[5][j] = 8'hFF;
    win[9][0] = 8'h00; win[9][1] = 8'h00; win[9][2] = 8'h00; win[9][3] = 8'h01;

    @(negedge clk);
    do_reset();

    // single window: max 200, avg (280+2)>>2 = 70
    drive(1'b1, 8'd10, 8'd200, 8'd30, 8'd40);
    idle(3);

    // average rounding corners: 3, 1, 255
    drive(1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
    idle(2);
    drive(1'b1, 8'd1, 8'd1, 8'd1, 8'd2);
    drive(1'b1, 8'd255, 8'd255, 8'd255, 8'd255);
    idle(3);

    // one full 4x3 frame back to back
    do_reset();
    for (int i = 0; i < 12; i++) drive(1'b1, win[i][0], win[i][1], win[i][2], win[i][3]);
    idle(3);
    chk("busy_after_frame", {busy_max, busy_avg}, 0);
    chk("outputs_frame", n_out, 12);

    // same frame with a bubble after every window
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, win[i][0], win[i][1], win[i][2], win[i][3]);
      drive(1'b0, '0, '0, '0, '0);
    end
    idle(3);
    chk("busy_after_bubbles", {busy_max, busy_avg}, 0);
    chk("outputs_bubbles", n_out, 12);

    // reset after the fifth output, then a clean frame
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, win[i][0], win[i][1], win[i][2], win[i][3]);
      if (n_out == 5) break;
    end
    chk("outputs_before_midreset", n_out, 5);
    do_reset();
    for (int i = 0; i < 12; i++) drive(1'b1, win[11-i][0], win[11-i][1], win[11-i][2], win[11-i][3]);
    idle(3);
    chk("outputs_after_midreset", n_out, 12);

    // two frames with no gap
    do_reset();
    for (int i = 0; i < 24; i++) drive(1'b1, win[i%12][0], win[i%12][1], win[i%12][2], win[i%12][3]);
    idle(3);
    chk("busy_after_two_frames", {busy_max, busy_avg}, 0);
    chk("outputs_two_frames", n_out, 24);
    chk("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
